// File: rtl/sector_dpram.sv
// sector_dpram: single-clock true dual-port RAM, the sector/track buffer between SD and disk.
// Define DPRAM_OUTREG_EN to add a second output register per port (read latency 2).
module sector_dpram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];
  logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;

  // Storage is never reset; writes are simply suppressed while reset_n is low.
  // Port B is assigned last so it wins a same-address dual write.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (wren_a) mem[address_a] <= data_a;
      if (wren_b) mem[address_b] <= data_b;
    end
  end

  // Reads sample the pre-edge contents, giving read-before-write on both ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= mem[address_a];
      rd_b_q <= mem[address_b];
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_a_q, out_b_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_a_q <= rd_a_q;
      out_b_q <= rd_b_q;
    end
  end

  assign q_a = out_a_q;
  assign q_b = out_b_q;
`else
  assign q_a = rd_a_q;
  assign q_b = rd_b_q;
`endif

endmodule

// File: tb/tb_sector_dpram.sv
// Self-checking bench for sector_dpram: directed plan steps plus randomized traffic
// compared against an array-based reference memory.
module tb_sector_dpram;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int Words = 1 << AW;
`ifdef DPRAM_OUTREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address_a, address_b;
  logic          wren_a, wren_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] q_a, q_b;

  int checks = 0;
  int failures = 0;

  // Reference: plain memory array, a "contents known" flag per word, and expected outputs.
  logic [DW-1:0] mdl [Words];
  bit            known [Words];
  logic [DW-1:0] exp_a, exp_b, pipe_a, pipe_b;
  bit            va, vb, pva, pvb;

  sector_dpram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address_a(address_a),
    .wren_a   (wren_a),
    .data_a   (data_a),
    .q_a      (q_a),
    .address_b(address_b),
    .wren_b   (wren_b),
    .data_b   (data_b),
    .q_b      (q_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One clock edge: update the reference from the spec rules, then compare #1 later.
  task automatic tick();
    logic [DW-1:0] ra, rb;
    bit ka, kb;
    @(posedge clk);
    if (!reset_n) begin
      exp_a = '0; exp_b = '0; pipe_a = '0; pipe_b = '0;
      va = 1; vb = 1; pva = 1; pvb = 1;
    end else begin
      ra = mdl[address_a]; ka = known[address_a];
      rb = mdl[address_b]; kb = known[address_b];
      if (wren_a) begin mdl[address_a] = data_a; known[address_a] = 1; end
      if (wren_b) begin mdl[address_b] = data_b; known[address_b] = 1; end
`ifdef DPRAM_OUTREG_EN
      exp_a = pipe_a; va = pva; pipe_a = ra; pva = ka;
      exp_b = pipe_b; vb = pvb; pipe_b = rb; pvb = kb;
`else
      exp_a = ra; va = ka;
      exp_b = rb; vb = kb;
`endif
    end
    #1;
    if (va) chk("model_q_a", q_a, exp_a);
    if (vb) chk("model_q_b", q_b, exp_b);
  endtask

  task automatic idle_ticks(input int n);
    wren_a = 0;
    wren_b = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 511));
    return AW'(14'h3FF0 + $urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < Words; i++) begin mdl[i] = '0; known[i] = 0; end
    exp_a = '0; exp_b = '0; pipe_a = '0; pipe_b = '0;
    va = 0; vb = 0; pva = 0; pvb = 0;
    reset_n = 0;
    address_a = '0; address_b = '0; wren_a = 0; wren_b = 0; data_a = '0; data_b = '0;

    // Reset held with random addresses and write attempts: outputs stay zero.
    for (int i = 0; i < 4; i++) begin
      address_a = AW'($urandom); address_b = AW'($urandom);
      wren_a = 1'($urandom); wren_b = 1'($urandom);
      data_a = DW'($urandom); data_b = DW'($urandom);
      tick();
      chk("reset_q_a", q_a, 8'h00);
      chk("reset_q_b", q_b, 8'h00);
    end
    reset_n = 1;
    wren_a = 0; wren_b = 0;

    // Known contents at the top of memory, written from port B.
    for (int i = 0; i < 16; i++) begin
      address_b = AW'(14'h3FF0 + i); data_b = DW'(8'hC0 + i); wren_b = 1;
      address_a = AW'(14'h3FF0 + i);
      tick();
    end
    wren_b = 0;

    // Port A writes, port B reads one cycle later.
    address_a = 14'h0200; data_a = 8'hA5; wren_a = 1; address_b = 14'h3FF0;
    tick();
    wren_a = 0; address_b = 14'h0200;
    idle_ticks(Lat);
    chk("a_wr_b_rd", q_b, 8'hA5);

    // Port B writes, port A reads.
    address_b = 14'h01FF; data_b = 8'h3C; wren_b = 1; address_a = 14'h3FF1;
    tick();
    wren_b = 0; address_a = 14'h01FF;
    idle_ticks(Lat);
    chk("b_wr_a_rd", q_a, 8'h3C);

    // Sweep 0x000-0x1FF through port A, read back through port B.
    for (int i = 0; i < 512; i++) begin
      address_a = AW'(i); data_a = DW'(i); wren_a = 1;
      tick();
    end
    wren_a = 0;
    for (int i = 0; i < 512 + Lat - 1; i++) begin
      address_b = AW'((i < 512) ? i : 511);
      tick();
      if (i >= Lat - 1) chk("sweep_b", q_b, DW'(i - (Lat - 1)));
    end

    // Same-port read-during-write returns the old word.
    address_a = 14'h0010; data_a = 8'h11; wren_a = 1;
    tick();
    data_a = 8'h22;
    tick();
    idle_ticks(Lat - 1);
    chk("rdw_old", q_a, 8'h11);
    tick();
    chk("rdw_new", q_a, 8'h22);

    // Dual write collision at 0x3FFF: both read old data, port B's data is kept.
    address_a = 14'h3FFF; address_b = 14'h3FFF;
    data_a = 8'h55; data_b = 8'hAA; wren_a = 1; wren_b = 1;
    tick();
    idle_ticks(Lat - 1);
    chk("coll_q_a_old", q_a, 8'hCF);
    chk("coll_q_b_old", q_b, 8'hCF);
    tick();
    chk("coll_q_a_new", q_a, 8'hAA);
    chk("coll_q_b_new", q_b, 8'hAA);

    // Reset asserted mid-cycle during a write: outputs clear at once, write is dropped.
    address_a = 14'h0010; data_a = 8'h99; wren_a = 1;
    address_b = 14'h0200; data_b = 8'h66; wren_b = 1;
    #3;
    reset_n = 0;
    exp_a = '0; exp_b = '0; pipe_a = '0; pipe_b = '0;
    #1;
    chk("async_rst_q_a", q_a, 8'h00);
    chk("async_rst_q_b", q_b, 8'h00);
    tick();
    reset_n = 1;
    wren_a = 0; wren_b = 0;
    idle_ticks(Lat);
    chk("post_rst_q_a", q_a, 8'h22);
    chk("post_rst_q_b", q_b, 8'hA5);

    // Randomized traffic over initialized regions, with forced address collisions.
    for (int i = 0; i < 400; i++) begin
      address_a = rand_addr();
      address_b = ($urandom_range(0, 3) == 0) ? address_a : rand_addr();
      wren_a = 1'($urandom); wren_b = 1'($urandom);
      data_a = DW'($urandom); data_b = DW'($urandom);
      tick();
    end
    idle_ticks(Lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
